// File: rtl/search_table_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the sorted search table.
package search_table_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_DEL = 2'b01;
    localparam logic [1:0] OP_UPD = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        SHIFT_UP,
        SHIFT_DN,
        WRITE,
        RESP
    } stateT;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/search_table_store.sv
// Key/data storage: combinational read, single-slot write and one-slot neighbour shift.
module search_table_store
    import search_table_pkg::*;
#(
    parameter  int unsigned KEY_W  = 48,
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned DEPTH  = 1024,
    localparam int unsigned AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [AW-1:0]     rdIdx,
    output logic [KEY_W-1:0]  rdKeyC,
    output logic [DATA_W-1:0] rdDataC,
    input  logic              wrEn,
    input  logic [AW-1:0]     wrIdx,
    input  logic [KEY_W-1:0]  wrKey,
    input  logic [DATA_W-1:0] wrData,
    input  logic              shEn,
    input  logic              shUp,
    input  logic [AW-1:0]     shIdx
);

    logic [KEY_W-1:0]  keyMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [AW-1:0]     srcIdx;

    assign rdKeyC  = keyMem[rdIdx];
    assign rdDataC = dataMem[rdIdx];
    assign srcIdx  = shUp ? shIdx - AW'(1) : shIdx + AW'(1);

    // Contents are deliberately unreset; the owner tracks the valid count.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            keyMem[wrIdx]  <= wrKey;
            dataMem[wrIdx] <= wrData;
        end else if (shEn) begin
            keyMem[shIdx]  <= keyMem[srcIdx];
            dataMem[shIdx] <= dataMem[srcIdx];
        end
    end

endmodule

// File: rtl/sorted_search_table.sv
// Sorted key/value table: one-compare-per-clock binary search plus add/delete/update/clear.
module sorted_search_table
    import search_table_pkg::*;
#(
    parameter  int unsigned KEY_W  = 48,
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned DEPTH  = 1024,
    localparam int unsigned AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [KEY_W-1:0]  search,
    output logic              rdy,
    output logic              done,
    output logic              found,
    output logic [DATA_W-1:0] result,
    input  logic              opReq,
    input  logic [1:0]        opCode,
    input  logic [KEY_W-1:0]  opSearch,
    input  logic [DATA_W-1:0] opResult,
    output logic              opRdy,
    output logic              opDone,
    output logic              opErr,
    output logic [AW:0]       numEntries,
    output logic              full
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = AW + 2;

    stateT             state;
    logic [CW-1:0]     count, lo, hi, pos, idx;
    logic [KEY_W-1:0]  key;
    logic [DATA_W-1:0] data, hitData;
    logic [1:0]        opc;
    logic              isLookup, hit, pendErr;

    logic [SW-1:0]     sum;
    logic [AW-1:0]     mid;
    logic [KEY_W-1:0]  midKey;
    logic [DATA_W-1:0] midData;
    logic              cmpHit, cmpLess, cmpEnd;
    logic [CW-1:0]     newLo, newHi;

    logic              endHit, curLookup, afterErr;
    logic [CW-1:0]     endPos, afterIdx;
    logic [1:0]        curOp;
    stateT             afterState;

    assign numEntries = count;
    assign sum        = SW'(lo) + SW'(hi);
    assign mid        = AW'(sum >> 1);

    search_table_store #(
        .KEY_W (KEY_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) uStore (
        .clk    (clk),
        .rdIdx  (mid),
        .rdKeyC (midKey),
        .rdDataC(midData),
        .wrEn   ((state == WRITE) && (opc != OP_DEL)),
        .wrIdx  (AW'(pos)),
        .wrKey  (key),
        .wrData (data),
        .shEn   ((state == SHIFT_UP) || (state == SHIFT_DN)),
        .shUp   (state == SHIFT_UP),
        .shIdx  (AW'(idx))
    );

    always_comb begin
        cmpHit  = (midKey == key);
        cmpLess = (midKey < key);
        newLo   = cmpLess ? CW'(mid) + CW'(1) : lo;
        newHi   = cmpLess ? hi : CW'(mid);
        cmpEnd  = cmpHit || (newLo >= newHi);
    end

    // Where a finished search leads; an empty table counts as an immediate miss at 0.
    always_comb begin
        endHit     = (state == SEARCH) && cmpHit;
        endPos     = (state != SEARCH) ? '0 : (cmpHit ? CW'(mid) : newLo);
        curLookup  = (state == IDLE) ? req : isLookup;
        curOp      = (state == IDLE) ? opCode : opc;
        afterState = RESP;
        afterErr   = 1'b0;
        afterIdx   = '0;
        if (!curLookup) begin
            case (curOp)
                OP_ADD: begin
                    if (endHit || full) begin
                        afterErr = 1'b1;
                    end else if (endPos == count) begin
                        afterState = WRITE;
                    end else begin
                        afterState = SHIFT_UP;
                        afterIdx   = count;
                    end
                end
                OP_DEL: begin
                    if (!endHit) begin
                        afterErr = 1'b1;
                    end else if (endPos == count - CW'(1)) begin
                        afterState = WRITE;
                    end else begin
                        afterState = SHIFT_DN;
                        afterIdx   = endPos;
                    end
                end
                OP_UPD: begin
                    if (!endHit) afterErr = 1'b1;
                    else         afterState = WRITE;
                end
                default: afterState = RESP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            full     <= 1'b0;
            rdy      <= 1'b1;
            opRdy    <= 1'b1;
            done     <= 1'b0;
            found    <= 1'b0;
            result   <= '0;
            opDone   <= 1'b0;
            opErr    <= 1'b0;
            lo       <= '0;
            hi       <= '0;
            pos      <= '0;
            idx      <= '0;
            key      <= '0;
            data     <= '0;
            hitData  <= '0;
            opc      <= OP_ADD;
            isLookup <= 1'b0;
            hit      <= 1'b0;
            pendErr  <= 1'b0;
        end else begin
            done   <= 1'b0;
            opDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (req || opReq) begin
                        isLookup <= req;
                        key      <= req ? search : opSearch;
                        data     <= opResult;
                        opc      <= opCode;
                        lo       <= '0;
                        hi       <= count;
                        hit      <= 1'b0;
                        pendErr  <= 1'b0;
                        rdy      <= 1'b0;
                        opRdy    <= 1'b0;
                        if (!req && opCode == OP_CLR) begin
                            count <= '0;
                            full  <= 1'b0;
                            state <= RESP;
                        end else if (count == '0) begin
                            state   <= afterState;
                            pendErr <= afterErr;
                            idx     <= afterIdx;
                            pos     <= '0;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (cmpEnd) begin
                        state   <= afterState;
                        pendErr <= afterErr;
                        idx     <= afterIdx;
                        pos     <= endPos;
                        hit     <= cmpHit;
                        hitData <= midData;
                    end else begin
                        lo <= newLo;
                        hi <= newHi;
                    end
                end
                SHIFT_UP: begin
                    if (idx == pos + CW'(1)) state <= WRITE;
                    else                     idx   <= idx - CW'(1);
                end
                SHIFT_DN: begin
                    if (idx == count - CW'(2)) state <= WRITE;
                    else                       idx   <= idx + CW'(1);
                end
                WRITE: begin
                    state <= RESP;
                    if (opc == OP_ADD) begin
                        count <= count + CW'(1);
                        full  <= (count + CW'(1)) == CW'(DEPTH);
                    end else if (opc == OP_DEL) begin
                        count <= count - CW'(1);
                        full  <= 1'b0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                    opRdy <= 1'b1;
                    if (isLookup) begin
                        done   <= 1'b1;
                        found  <= hit;
                        result <= hit ? hitData : '0;
                    end else begin
                        opDone <= 1'b1;
                        opErr  <= pendErr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sorted_search_table.sv
// Self-checking bench: sorted-queue reference model plus directed lookup/maintenance sequences.
module tb_sorted_search_table;

    localparam int unsigned KEY_W  = 48;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam logic [1:0] ADD = 2'b00, DEL = 2'b01, UPD = 2'b10, CLR = 2'b11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req = 1'b0;
    logic [KEY_W-1:0]  search = '0;
    logic              rdy, done, found;
    logic [DATA_W-1:0] result;
    logic              opReq = 1'b0;
    logic [1:0]        opCode = 2'b00;
    logic [KEY_W-1:0]  opSearch = '0;
    logic [DATA_W-1:0] opResult = '0;
    logic              opRdy, opDone, opErr;
    logic [3:0]        numEntries;
    logic              full;

    sorted_search_table #(.KEY_W(KEY_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req(req), .search(search), .rdy(rdy), .done(done),
        .found(found), .result(result), .opReq(opReq), .opCode(opCode), .opSearch(opSearch),
        .opResult(opResult), .opRdy(opRdy), .opDone(opDone), .opErr(opErr),
        .numEntries(numEntries), .full(full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model: sorted queues of keys and data.
    logic [KEY_W-1:0]  mKey[$];
    logic [DATA_W-1:0] mData[$];

    bit lkPend = 0, opPend = 0;
    int lkAt, opAt, lkLat, opLat, expCount;
    bit expFound, expErr;
    logic [DATA_W-1:0] expResult;
    bit lastFound = 0, lastErr = 0;
    logic [DATA_W-1:0] lastResult = '0;
    int lastLat = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void failNote(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=no-event (t=%0t)", name, $time);
    endfunction

    function automatic void mSearch(input logic [KEY_W-1:0] k, output int steps, output bit hit, output int pos);
        int lo, hi, m;
        lo = 0; hi = mKey.size(); steps = 0; hit = 0; pos = 0;
        while (lo < hi) begin
            m = (lo + hi) / 2;
            steps++;
            if (mKey[m] == k) begin
                hit = 1; pos = m;
                return;
            end
            if (mKey[m] < k) lo = m + 1;
            else             hi = m;
        end
        pos = lo;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (!lkPend) failNote("spurious_done");
                else begin
                    chk("lk_found", 64'(found), 64'(expFound));
                    chk("lk_result", 64'(result), 64'(expResult));
                    chk("lk_latency", 64'(cyc - lkAt), 64'(lkLat));
                    lastFound = found; lastResult = result; lastLat = cyc - lkAt;
                    lkPend = 0;
                end
            end else begin
                chk("found_hold", 64'(found), 64'(lastFound));
                chk("result_hold", 64'(result), 64'(lastResult));
            end
            if (opDone) begin
                if (!opPend) failNote("spurious_opDone");
                else begin
                    chk("op_err", 64'(opErr), 64'(expErr));
                    chk("op_count", 64'(numEntries), 64'(expCount));
                    chk("op_full", 64'(full), 64'(expCount == DEPTH));
                    chk("op_latency", 64'(cyc - opAt), 64'(opLat));
                    lastErr = opErr; lastLat = cyc - opAt;
                    opPend = 0;
                end
            end
            if (rdy && !lkPend && !opPend)
                chk("idle_count", 64'(numEntries), 64'(mKey.size()));
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (!rdy && n < 200) begin @(negedge clk); n++; end
        if (!rdy) failNote("rdy_timeout");
    endtask

    task automatic waitDone();
        int n = 0;
        while ((lkPend || opPend) && n < 200) begin @(negedge clk); n++; end
        if (lkPend || opPend) begin
            failNote("txn_timeout");
            lkPend = 0; opPend = 0;
        end
        @(negedge clk);
    endtask

    task automatic planLookup(input logic [KEY_W-1:0] k);
        int steps, pos; bit hit;
        mSearch(k, steps, hit, pos);
        expFound  = hit;
        expResult = hit ? mData[pos] : '0;
        lkLat = steps + 1;
        lkAt  = cyc + 1;
        lkPend = 1;
    endtask

    task automatic planOp(input logic [1:0] code, input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] d);
        int steps, pos, n; bit hit;
        mSearch(k, steps, hit, pos);
        n = mKey.size();
        expErr = 0;
        case (code)
            CLR: begin opLat = 1; mKey.delete(); mData.delete(); end
            ADD: begin
                if (hit || n == DEPTH) begin expErr = 1; opLat = steps + 1; end
                else begin opLat = steps + (n - pos) + 2; mKey.insert(pos, k); mData.insert(pos, d); end
            end
            DEL: begin
                if (!hit) begin expErr = 1; opLat = steps + 1; end
                else begin opLat = steps + (n - 1 - pos) + 2; mKey.delete(pos); mData.delete(pos); end
            end
            default: begin
                if (!hit) begin expErr = 1; opLat = steps + 1; end
                else begin opLat = steps + 2; mData[pos] = d; end
            end
        endcase
        expCount = mKey.size();
        opAt = cyc + 1;
        opPend = 1;
    endtask

    task automatic lookup(input logic [KEY_W-1:0] k);
        waitIdle();
        planLookup(k);
        req = 1; search = k;
        @(negedge clk); req = 0;
        waitDone();
    endtask

    task automatic op(input logic [1:0] code, input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] d);
        waitIdle();
        planOp(code, k, d);
        opReq = 1; opCode = code; opSearch = k; opResult = d;
        @(negedge clk); opReq = 0;
        waitDone();
    endtask

    task automatic dualReq(input logic [KEY_W-1:0] lk, input logic [KEY_W-1:0] ok, input logic [DATA_W-1:0] d);
        int n = 0;
        waitIdle();
        planLookup(lk);
        req = 1; search = lk;
        opReq = 1; opCode = ADD; opSearch = ok; opResult = d;
        @(negedge clk); req = 0;
        while (!rdy && n < 200) begin @(negedge clk); n++; end
        if (!rdy) failNote("dual_timeout");
        planOp(ADD, ok, d);
        @(negedge clk); opReq = 0;
        waitDone();
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_rdy"}, 64'(rdy), 64'd1);
        chk({tag, "_opRdy"}, 64'(opRdy), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_found"}, 64'(found), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_opDone"}, 64'(opDone), 64'd0);
        chk({tag, "_opErr"}, 64'(opErr), 64'd0);
        chk({tag, "_numEntries"}, 64'(numEntries), 64'd0);
        chk({tag, "_full"}, 64'(full), 64'd0);
    endtask

    task automatic resetMidShift(input logic [KEY_W-1:0] k);
        int steps, pos, at; bit hit;
        waitIdle();
        mSearch(k, steps, hit, pos);
        at = cyc + 1;
        opReq = 1; opCode = ADD; opSearch = k; opResult = 16'h7777;
        @(negedge clk); opReq = 0;
        while (cyc < at + steps + 2) @(negedge clk);
        chk("busy_at_reset", 64'(rdy), 64'd0);
        reset = 1;
        lastFound = 0; lastResult = '0;
        mKey.delete(); mData.delete();
        @(negedge clk); reset = 0;
        @(negedge clk);
        checkReset("midrst");
        repeat (12) @(negedge clk);
    endtask

    task automatic dumpCheck();
        for (int i = 0; i < mKey.size(); i++) begin
            chk($sformatf("dump_key%0d", i), 64'(dut.uStore.keyMem[i]), 64'(mKey[i]));
            chk($sformatf("dump_data%0d", i), 64'(dut.uStore.dataMem[i]), 64'(mData[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        checkReset("por");

        lookup(48'd5);
        chk("pin_lk5_found", 64'(lastFound), 64'd0);
        chk("pin_lk5_result", 64'(lastResult), 64'd0);
        chk("pin_lk5_lat", 64'(lastLat), 64'd1);

        op(ADD, 48'd30, 16'hA0A0);
        chk("pin_add30_err", 64'(lastErr), 64'd0);
        op(ADD, 48'd10, 16'hB0B0);
        chk("pin_add10_lat", 64'(lastLat), 64'd4);
        op(ADD, 48'd20, 16'hC0C0);
        chk("pin_add20_err", 64'(lastErr), 64'd0);
        lookup(48'd10); chk("pin_lk10", 64'(lastResult), 64'hB0B0);
        lookup(48'd20); chk("pin_lk20", 64'(lastResult), 64'hC0C0);
        lookup(48'd30); chk("pin_lk30", 64'(lastResult), 64'hA0A0);
        dumpCheck();

        op(ADD, 48'd20, 16'h1111);
        chk("pin_dup_err", 64'(lastErr), 64'd1);
        chk("pin_dup_count", 64'(numEntries), 64'd3);
        op(UPD, 48'd20, 16'hD0D0);
        lookup(48'd20); chk("pin_upd20", 64'(lastResult), 64'hD0D0);
        op(UPD, 48'd99, 16'h2222);
        chk("pin_upd99_err", 64'(lastErr), 64'd1);

        op(DEL, 48'd10, '0);
        op(DEL, 48'd30, '0);
        chk("pin_del_count", 64'(numEntries), 64'd1);
        lookup(48'd10); chk("pin_lk10_gone", 64'(lastFound), 64'd0);
        lookup(48'd20); chk("pin_lk20_kept", 64'(lastFound), 64'd1);
        op(DEL, 48'd10, '0);
        chk("pin_del10_err", 64'(lastErr), 64'd1);

        op(ADD, 48'd0, 16'h0001);
        op(ADD, {KEY_W{1'b1}}, 16'hFFFE);
        lookup(48'd0);
        lookup({KEY_W{1'b1}}); chk("pin_lk_ones", 64'(lastResult), 64'hFFFE);
        op(DEL, {KEY_W{1'b1}}, '0);
        op(DEL, 48'd0, '0);
        op(DEL, 48'd20, '0);
        chk("pin_empty", 64'(numEntries), 64'd0);
        lookup(48'd20);

        for (int i = 1; i <= 8; i++) op(ADD, 48'(i * 100), 16'(i));
        chk("pin_full", 64'(full), 64'd1);
        chk("pin_full_count", 64'(numEntries), 64'd8);
        dumpCheck();
        op(ADD, 48'd50, 16'h3333);
        chk("pin_ninth_err", 64'(lastErr), 64'd1);
        lookup(48'd800); chk("pin_lk800", 64'(lastResult), 64'd8);
        op(CLR, '0, '0);
        chk("pin_clr_lat", 64'(lastLat), 64'd1);
        chk("pin_clr_count", 64'(numEntries), 64'd0);
        chk("pin_clr_full", 64'(full), 64'd0);

        dualReq(48'd50, 48'd50, 16'h5555);
        chk("pin_dual_lk_first", 64'(lastFound), 64'd0);
        lookup(48'd50); chk("pin_dual_op_after", 64'(lastResult), 64'h5555);

        op(CLR, '0, '0);
        for (int i = 7; i >= 1; i--) op(ADD, 48'(i * 10), 16'(i));
        dumpCheck();
        resetMidShift(48'd5);
        lookup(48'd10);
        chk("pin_post_rst_miss", 64'(lastFound), 64'd0);
        chk("pin_post_rst_count", 64'(numEntries), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
